// File: rtl/sword_attack_sequencer.sv
// Sword-up attack animation sequencer: steps a 3-frame sprite through vsync-paced holds
// and generates the shared sprite ROM address plus latency-aligned pixel outputs.
module sword_attack_sequencer #(
   parameter int SPR_W       = 32,
   parameter int SPR_H       = 32,
   parameter int NUM_FRAMES  = 3,
   parameter int HOLD_FRAMES = 4,
   parameter int ADDR_W      = 10,
   parameter int IDX_W       = 3,
   parameter int TRANSP_IDX  = 0
) (
   input  logic              vga_clk,
   input  logic              Reset,
   input  logic              frame_tick,
   input  logic              attack_req,
   input  logic [9:0]        pos_x,
   input  logic [9:0]        pos_y,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              blank,
   input  logic [IDX_W-1:0]  rom_q,
   output logic [ADDR_W-1:0] rom_address,
   output logic [1:0]        frame_sel,
   output logic              busy,
   output logic              attack_done,
   output logic              pixel_valid,
   output logic [IDX_W-1:0]  pixel_index
);

   localparam int HC_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

   typedef enum logic [1:0] {IDLE, ARM, PLAY, DONE} state_t;

   state_t          state_q;
   logic [1:0]      frame_sel_q;
   logic [HC_W-1:0] hold_cnt_q;
   logic            busy_q, done_q;
   logic            in_box_d1_q, blank_d1_q, play_d1_q;

   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         frame_sel_q <= '0;
         hold_cnt_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               frame_sel_q <= '0;
               hold_cnt_q  <= '0;
               // a tick coinciding with the request is deliberately not consumed here
               if (attack_req) begin
                  state_q <= ARM;
                  busy_q  <= 1'b1;
               end
            end
            ARM: begin
               if (frame_tick) begin
                  state_q     <= PLAY;
                  frame_sel_q <= '0;
                  hold_cnt_q  <= '0;
               end
            end
            PLAY: begin
               if (frame_tick) begin
                  if (hold_cnt_q < HC_W'(HOLD_FRAMES - 1)) begin
                     hold_cnt_q <= hold_cnt_q + 1'b1;
                  end else if (frame_sel_q < 2'(NUM_FRAMES - 1)) begin
                     hold_cnt_q  <= '0;
                     frame_sel_q <= frame_sel_q + 1'b1;
                  end else begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state_q     <= IDLE;
               frame_sel_q <= '0;
               hold_cnt_q  <= '0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // 11-bit compare so a sprite near the right/bottom edge clips instead of wrapping
   logic [10:0] x_ext, y_ext, px_ext, py_ext, dx, dy;
   logic        in_box;

   always_comb begin
      x_ext  = {1'b0, DrawX};
      y_ext  = {1'b0, DrawY};
      px_ext = {1'b0, pos_x};
      py_ext = {1'b0, pos_y};
      dx     = x_ext - px_ext;
      dy     = y_ext - py_ext;
      in_box = (x_ext >= px_ext) && (x_ext < px_ext + 11'(SPR_W)) &&
               (y_ext >= py_ext) && (y_ext < py_ext + 11'(SPR_H));
      rom_address = '0;
      if (in_box)
         rom_address = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);
   end

   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         in_box_d1_q <= 1'b0;
         blank_d1_q  <= 1'b0;
         play_d1_q   <= 1'b0;
      end else begin
         in_box_d1_q <= in_box;
         blank_d1_q  <= blank;
         play_d1_q   <= (state_q == PLAY);
      end
   end

   always_comb begin
      pixel_valid = in_box_d1_q & blank_d1_q & play_d1_q & (rom_q != IDX_W'(TRANSP_IDX));
      pixel_index = pixel_valid ? rom_q : '0;
   end

   assign frame_sel   = frame_sel_q;
   assign busy        = busy_q;
   assign attack_done = done_q;

endmodule

// File: tb/tb_sword_attack_sequencer.sv
// Directed bench for sword_attack_sequencer: FSM sequencing, reset abort, address and pixel path.
module tb_sword_attack_sequencer;

   logic       vga_clk = 1'b0;
   logic       Reset, frame_tick, attack_req, blank;
   logic [9:0] pos_x, pos_y, DrawX, DrawY;
   logic [2:0] rom_q;
   logic [9:0] rom_address;
   logic [1:0] frame_sel;
   logic       busy, attack_done, pixel_valid;
   logic [2:0] pixel_index;

   int n_chk = 0, n_err = 0, done_cnt = 0;

   sword_attack_sequencer dut (
      .vga_clk(vga_clk), .Reset(Reset), .frame_tick(frame_tick), .attack_req(attack_req),
      .pos_x(pos_x), .pos_y(pos_y), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .rom_q(rom_q), .rom_address(rom_address), .frame_sel(frame_sel), .busy(busy),
      .attack_done(attack_done), .pixel_valid(pixel_valid), .pixel_index(pixel_index)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge vga_clk);
      #1;
      if (attack_done === 1'b1) done_cnt++;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; frame_tick = 1'b0; attack_req = 1'b0; blank = 1'b0;
      pos_x = '0; pos_y = '0; DrawX = '0; DrawY = '0; rom_q = 3'd5;
      step(); step();
      check("rst_busy", busy, 0);
      check("rst_fsel", frame_sel, 0);
      check("rst_done", attack_done, 0);
      check("rst_pv", pixel_valid, 0);
      check("rst_pidx", pixel_index, 0);
      Reset = 1'b0;
      step();

      // request and tick in the same IDLE cycle: tick must not advance
      attack_req = 1'b1; frame_tick = 1'b1;
      step();
      attack_req = 1'b0; frame_tick = 1'b0;
      check("same_busy", busy, 1);
      check("same_fsel", frame_sel, 0);
      tick();                                   // ARM -> PLAY
      for (int i = 0; i < 3; i++) tick();       // hold 1..3
      check("same_fsel_hold", frame_sel, 0);
      tick();
      check("same_fsel_adv", frame_sel, 1);

      // pixel path while in PLAY
      pos_x = 10'd100; pos_y = 10'd50; DrawX = 10'd131; DrawY = 10'd81; blank = 1'b1;
      #1;
      check("addr_1023", rom_address, 1023);
      step();
      DrawX = 10'd132; rom_q = 3'd5;
      #1;
      check("addr_out", rom_address, 0);
      check("pv_opaque", pixel_valid, 1);
      check("pidx_5", pixel_index, 5);
      rom_q = 3'd0;
      #1;
      check("pv_transp", pixel_valid, 0);
      check("pidx_transp", pixel_index, 0);
      step();
      rom_q = 3'd5;
      #1;
      check("pv_outbox", pixel_valid, 0);

      pos_x = 10'd620; pos_y = 10'd0; DrawX = 10'd639; DrawY = 10'd0;
      #1;
      check("addr_19", rom_address, 19);
      step();
      rom_q = 3'd3; DrawX = 10'd0;
      #1;
      check("pv_edge", pixel_valid, 1);
      check("addr_nowrap", rom_address, 0);
      step();
      #1;
      check("pv_nowrap", pixel_valid, 0);
      DrawX = 10'd639; blank = 1'b0;
      step();
      #1;
      check("pv_blank", pixel_valid, 0);
      blank = 1'b1;

      // reset mid-PLAY with frame_sel=1 aborts without a done pulse
      check("pre_rst_fsel", frame_sel, 1);
      done_cnt = 0;
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_fsel", frame_sel, 0);
      check("abort_done", attack_done, 0);
      step(); step();
      check("abort_nodone", done_cnt, 0);

      // single-pulse request then 12 PLAY ticks
      attack_req = 1'b1;
      step();
      attack_req = 1'b0;
      check("arm_busy", busy, 1);
      tick();
      for (int i = 0; i < 12; i++) begin
         check($sformatf("seq_fsel_%0d", i), frame_sel, i / 4);
         check($sformatf("seq_busy_%0d", i), busy, 1);
         tick();
      end
      check("seq_done", attack_done, 1);
      step();
      check("seq_done_1cyc", attack_done, 0);
      check("seq_busy_off", busy, 0);
      check("seq_fsel_idle", frame_sel, 0);
      step();
      check("seq_ignore_idle", busy, 0);

      // request held high across an attack
      done_cnt = 0;
      attack_req = 1'b1;
      step();
      tick();
      for (int i = 0; i < 12; i++) tick();
      check("held_done", attack_done, 1);
      step();
      check("held_idle", busy, 0);
      step();
      check("held_rearm", busy, 1);
      check("held_done_cnt", done_cnt, 1);
      attack_req = 1'b0;
      for (int i = 0; i < 13; i++) tick();
      step(); step();
      check("held_done_cnt2", done_cnt, 2);
      check("held_end_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
